// File: rtl/fib_index_finder_if.sv
// Go/done handshake bundle shared by the Fibonacci generator and index finder.
interface fib_index_finder_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_WIDTH = 5
);
  logic                 go;
  logic [WIDTH-1:0]     numberIn;
  logic [IDX_WIDTH-1:0] indexOut;
  logic                 isFib;
  logic                 done;
  logic                 busy;

  // Requester side: issues go/numberIn, observes the result.
  modport master (
    output go,
    output numberIn,
    input  indexOut,
    input  isFib,
    input  done,
    input  busy
  );

  // Finder side: accepts go/numberIn, produces the result.
  modport slave (
    input  go,
    input  numberIn,
    output indexOut,
    output isFib,
    output done,
    output busy
  );
endinterface

// File: rtl/fib_index_finder.sv
// Iterative inverse Fibonacci: walks F(0), F(1), ... one term per clock until
// the running term reaches or passes the captured target, then reports the
// matching index (or the index of the largest smaller term) with a done pulse.
module fib_index_finder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_WIDTH = 5
) (
  input logic               clk,
  input logic               reset,
  fib_index_finder_if.slave bus
);

  // One extra bit so the first term above any WIDTH-bit target is representable.
  localparam int unsigned TW = WIDTH + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     target_q;
  logic [TW-1:0]        a_q;
  logic [TW-1:0]        b_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [IDX_WIDTH-1:0] index_q;
  logic                 is_fib_q;
  logic                 done_q;
  logic                 busy_q;

  logic [TW-1:0]        b_d;
  logic [IDX_WIDTH-1:0] idx_d;
  logic [IDX_WIDTH-1:0] idx_below_c;
  logic [TW-1:0]        target_ext_c;
  logic                 a_eq_c;
  logic                 a_gt_c;

  // Next term, next index and the comparison of the current term to the target.
  always_comb begin
    target_ext_c = TW'(target_q);
    b_d          = a_q + b_q;
    idx_d        = idx_q + IDX_WIDTH'(1);
    idx_below_c  = idx_q - IDX_WIDTH'(1);
    a_eq_c       = (a_q == target_ext_c);
    a_gt_c       = (a_q > target_ext_c);
  end

  // Control FSM, term registers and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      index_q  <= '0;
      is_fib_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.go) begin
            target_q <= bus.numberIn;
            a_q      <= '0;
            b_q      <= TW'(1);
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SEARCH;
          end
        end
        SEARCH: begin
          if (a_eq_c) begin
            index_q  <= idx_q;
            is_fib_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (a_gt_c) begin
            // a > target implies a > 0, so idx is at least 1 here.
            index_q  <= idx_below_c;
            is_fib_q <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            a_q   <= b_q;
            b_q   <= b_d;
            idx_q <= idx_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive the interface straight from the result registers.
  assign bus.indexOut = index_q;
  assign bus.isFib    = is_fib_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fib_index_finder.sv
// Table-driven bench with a result scoreboard for fib_index_finder.
module tb_fib_index_finder;

  logic clk;
  logic reset;

  fib_index_finder_if #(.WIDTH(16), .IDX_WIDTH(5)) bus ();

  fib_index_finder #(.WIDTH(16), .IDX_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit fib;
    int lat;
    int e0;
  } exp_t;

  typedef struct {
    int num;
    int idx;
    bit fib;
    int lat;
  } vec_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the sequence until the term reaches the value.
  task automatic model(input int v, output exp_t e);
    int a;
    int b;
    int t;
    int i;
    a = 0;
    b = 1;
    i = 0;
    while (a < v) begin
      t = a + b;
      a = b;
      b = t;
      i++;
    end
    e.fib = (a == v);
    e.idx = e.fib ? i : i - 1;
    e.lat = i + 1;
    e.e0  = 0;
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("indexOut", int'(bus.indexOut), e.idx);
        check("isFib", int'(bus.isFib), int'(e.fib));
        check("latency", cyc - e.e0, e.lat);
        check("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  // Issue one accepted request; E0 is the next rising edge.
  task automatic start(input int v, input exp_t e);
    @(negedge clk);
    bus.numberIn = 16'(v);
    bus.go       = 1'b1;
    e.e0         = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.go = 1'b0;
    @(negedge clk);
    check("busy_after_go", int'(bus.busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic no_done(input string name, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    exp_t e;
    int   base;

    vecs[0] = '{num: 8,     idx: 6,  fib: 1'b1, lat: 7};
    vecs[1] = '{num: 55,    idx: 10, fib: 1'b1, lat: 11};
    vecs[2] = '{num: 46368, idx: 24, fib: 1'b1, lat: 25};
    vecs[3] = '{num: 50,    idx: 9,  fib: 1'b0, lat: 11};
    vecs[4] = '{num: 65535, idx: 24, fib: 1'b0, lat: 26};
    vecs[5] = '{num: 0,     idx: 0,  fib: 1'b1, lat: 1};
    vecs[6] = '{num: 1,     idx: 1,  fib: 1'b1, lat: 2};
    vecs[7] = '{num: 2,     idx: 3,  fib: 1'b1, lat: 4};
    vecs[8] = '{num: 4,     idx: 4,  fib: 1'b0, lat: 6};
    vecs[9] = '{num: 100,   idx: 11, fib: 1'b0, lat: 13};

    reset        = 1'b1;
    bus.go       = 1'b0;
    bus.numberIn = '0;
    repeat (3) @(negedge clk);
    check("rst_indexOut", int'(bus.indexOut), 0);
    check("rst_isFib", int'(bus.isFib), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Fixed vectors.
    for (int i = 0; i < 10; i++) begin
      e = '{idx: vecs[i].idx, fib: vecs[i].fib, lat: vecs[i].lat, e0: 0};
      start(vecs[i].num, e);
      wait_idle();
    end

    // Random values against the reference walk.
    for (int i = 0; i < 6; i++) begin
      int v;
      v = int'($urandom_range(0, 65535));
      model(v, e);
      start(v, e);
      wait_idle();
    end

    // go while busy with a new numberIn is ignored.
    e = '{idx: 10, fib: 1'b1, lat: 11, e0: 0};
    start(55, e);
    base = sb[0].e0;
    while (cyc < base + 2) @(negedge clk);
    bus.numberIn = 16'd8;
    bus.go       = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    wait_idle();
    no_done("no_second_done", 15);

    // go held high: back-to-back searches, one IDLE cycle between results.
    @(negedge clk);
    bus.numberIn = 16'd13;
    bus.go       = 1'b1;
    base         = cyc + 1;
    for (int k = 0; k < 3; k++) sb.push_back('{idx: 7, fib: 1'b1, lat: 8, e0: base + 9 * k});
    while (cyc < base + 18) @(negedge clk);
    bus.go = 1'b0;
    wait_idle();
    no_done("no_extra_done", 12);

    // Reset in mid-search drops the result immediately.
    e = '{idx: 10, fib: 1'b1, lat: 11, e0: 0};
    start(55, e);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_indexOut", int'(bus.indexOut), 0);
    check("midrst_isFib", int'(bus.isFib), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_busy", int'(bus.busy), 0);
    #9 reset = 1'b0;
    no_done("no_done_after_reset", 15);
    check("busy_after_reset", int'(bus.busy), 0);
    start(55, e);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
